// File: rtl/clkdiv_scale_ctrl.sv
// Sequences changes to the clock divider's scale so they land only on output-period boundaries.
// Optional ramp mode (one step per period) is compiled in with `define CLKDIV_CTRL_RAMP_EN.
module clkdiv_scale_ctrl #(
  parameter int               WIDTH          = 8,
  parameter logic [WIDTH-1:0] RESET_SCALE    = WIDTH'(1),
  parameter int               TIMEOUT_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_scale,
  input  logic             req_mode,
  input  logic             period_end,
  output logic [WIDTH-1:0] scale_out,
  output logic             update,
  output logic             busy,
  output logic             timeout_flag,
  output logic [15:0]      period_cnt
);

`ifdef CLKDIV_CTRL_RAMP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_BND = 2'd1, RAMP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_BND = 2'd1} state_t;
  logic unused_mode;
  assign unused_mode = req_mode;
`endif

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q;
  logic [15:0]      tmo_q;
  logic             accept, tmo_hit, step;
  logic [WIDTH-1:0] step_val;

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  always_comb begin
    accept   = req_valid && (state_q == IDLE);
    // Timeout only forces a step on a cycle the divider did not supply a boundary.
    tmo_hit  = busy && !period_end && (tmo_q == TMO_LAST);
    step     = busy && (period_end || tmo_hit);
    step_val = target_q;
    state_d  = state_q;
`ifdef CLKDIV_CTRL_RAMP_EN
    if (state_q == RAMP)
      step_val = (scale_out < target_q) ? scale_out + WIDTH'(1) : scale_out - WIDTH'(1);
`endif
    case (state_q)
      IDLE: begin
        if (accept && (req_scale != scale_out)) begin
`ifdef CLKDIV_CTRL_RAMP_EN
          state_d = req_mode ? RAMP : WAIT_BND;
`else
          state_d = WAIT_BND;
`endif
        end
      end
      WAIT_BND: if (step) state_d = IDLE;
`ifdef CLKDIV_CTRL_RAMP_EN
      RAMP:     if (step && (step_val == target_q)) state_d = IDLE;
`endif
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      scale_out    <= RESET_SCALE;
      target_q     <= RESET_SCALE;
      tmo_q        <= '0;
      update       <= 1'b0;
      timeout_flag <= 1'b0;
      period_cnt   <= '0;
    end else begin
      state_q <= state_d;
      update  <= step;
      if (step) scale_out <= step_val;
      if (accept) target_q <= req_scale;

      if (accept || step)             tmo_q <= '0;
      else if (busy && !period_end)   tmo_q <= tmo_q + 16'd1;

      if (accept)                     timeout_flag <= 1'b0;
      else if (tmo_hit)               timeout_flag <= 1'b1;

      // The boundary that triggers a step is not counted: the count restarts with the new scale.
      if (step)                                    period_cnt <= '0;
      else if (period_end && period_cnt != 16'hFFFF) period_cnt <= period_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_clkdiv_scale_ctrl.sv
// Scoreboard bench for clkdiv_scale_ctrl: expected scale values queued per request, checked on each update.
module tb_clkdiv_scale_ctrl;
  logic       clk = 1'b0;
  logic       rst, req_valid, req_ready, req_mode, period_end;
  logic [7:0] req_scale, scale_out;
  logic       update, busy, timeout_flag;
  logic [15:0] period_cnt;

  int n_chk = 0, n_err = 0, upd_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_scale;

  clkdiv_scale_ctrl #(.WIDTH(8), .RESET_SCALE(8'd1), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_scale(req_scale), .req_mode(req_mode), .period_end(period_end),
    .scale_out(scale_out), .update(update), .busy(busy),
    .timeout_flag(timeout_flag), .period_cnt(period_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst && update) begin
      upd_cnt++;
      if (exp_q.size() == 0) chk("unexpected_update", 1, 0);
      else chk("upd_scale", scale_out, exp_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] s, input logic m, input logic pe);
    chk("req_ready", req_ready, 1);
    if (s != model_scale) begin
`ifdef CLKDIV_CTRL_RAMP_EN
      if (m) begin
        while (model_scale != s) begin
          model_scale = (model_scale < s) ? model_scale + 8'd1 : model_scale - 8'd1;
          exp_q.push_back(model_scale);
        end
      end else exp_q.push_back(s);
`else
      exp_q.push_back(s);
`endif
    end
    model_scale = s;
    req_valid = 1'b1; req_scale = s; req_mode = m; period_end = pe;
    tick();
    req_valid = 1'b0; period_end = 1'b0;
  endtask

  task automatic pulse_pe();
    period_end = 1'b1; tick(); period_end = 1'b0; tick();
  endtask

  task automatic finish_req();
    int n = 0;
    while (busy && n < 1000) begin pulse_pe(); n++; end
    chk("finish_bound", (n < 1000), 1);
    tick();
  endtask

  initial begin
    int base, k;
    rst = 1'b1; req_valid = 1'b0; req_scale = '0; req_mode = 1'b0; period_end = 1'b0;
    model_scale = 8'd1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_scale", scale_out, 1);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pcnt", period_cnt, 0);
    chk("rst_update", update, 0);
    chk("rst_tflag", timeout_flag, 0);
    tick();

    // Jump to 8 on a boundary five cycles after acceptance
    base = upd_cnt;
    send(8'd8, 1'b0, 1'b0);
    chk("jump_busy", busy, 1);
    repeat (5) tick();
    chk("jump_hold", scale_out, 1);
    period_end = 1'b1; tick(); period_end = 1'b0;
    chk("jump_update", update, 1);
    chk("jump_scale", scale_out, 8);
    chk("jump_busy_drop", busy, 0);
    chk("jump_pcnt0", period_cnt, 0);
    tick();
    chk("jump_upd_once", upd_cnt - base, 1);
    pulse_pe(); pulse_pe();
    chk("idle_pcnt", period_cnt, 2);

    // Ramp up 3 -> 6, then down to 4
    send(8'd3, 1'b0, 1'b0); finish_req();
    base = upd_cnt;
    send(8'd6, 1'b1, 1'b0); finish_req();
`ifdef CLKDIV_CTRL_RAMP_EN
    chk("ramp_up_updates", upd_cnt - base, 3);
`else
    chk("ramp_up_updates", upd_cnt - base, 1);
`endif
    chk("ramp_up_final", scale_out, 6);
    base = upd_cnt;
    send(8'd4, 1'b1, 1'b0); finish_req();
`ifdef CLKDIV_CTRL_RAMP_EN
    chk("ramp_dn_updates", upd_cnt - base, 2);
`else
    chk("ramp_dn_updates", upd_cnt - base, 1);
`endif
    chk("ramp_dn_final", scale_out, 4);
    chk("ramp_tflag", timeout_flag, 0);

    // Timeout forces the jump 16 cycles after acceptance
    send(8'd5, 1'b0, 1'b0);
    k = 0;
    while (!update && k < 40) begin tick(); k++; end
    chk("tmo_latency", k, 16);
    chk("tmo_scale", scale_out, 5);
    chk("tmo_flag", timeout_flag, 1);
    tick();
    send(8'd7, 1'b0, 1'b0);
    chk("tmo_flag_clr", timeout_flag, 0);
    finish_req();

    // Null request
    base = upd_cnt;
    send(8'd7, 1'b0, 1'b0);
    chk("null_busy", busy, 0);
    tick(); tick();
    chk("null_updates", upd_cnt - base, 0);

    // Boundary in the acceptance cycle is not a step
    send(8'd9, 1'b0, 1'b1);
    chk("accpe_update", update, 0);
    chk("accpe_busy", busy, 1);
    chk("accpe_scale", scale_out, 7);
    finish_req();
    chk("accpe_final", scale_out, 9);

    // Ramp 255 -> 0 without wrap
    send(8'd255, 1'b0, 1'b0); finish_req();
    base = upd_cnt;
    send(8'd0, 1'b1, 1'b0); finish_req();
`ifdef CLKDIV_CTRL_RAMP_EN
    chk("wrap_updates", upd_cnt - base, 255);
`else
    chk("wrap_updates", upd_cnt - base, 1);
`endif
    chk("wrap_final", scale_out, 0);

    // Reset in the middle of a request
    send(8'd10, 1'b1, 1'b0);
    pulse_pe(); pulse_pe();
`ifdef CLKDIV_CTRL_RAMP_EN
    chk("midramp_scale", scale_out, 2);
    chk("midramp_busy", busy, 1);
`else
    chk("midramp_scale", scale_out, 10);
`endif
    rst = 1'b1; tick(); rst = 1'b0;
    exp_q.delete();
    model_scale = 8'd1;
    chk("rst_mid_scale", scale_out, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", req_ready, 1);
    tick(); tick();
    chk("rst_mid_hold", scale_out, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
